// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: architectural register file with write-back bypass and
// immediate select, followed by a valid/ready pipeline output register.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_en, wb_addr, wb_data    write-back port into the register file
//   in_valid / in_ready        handshake with the decode stage
//   src_addr, dst_addr         source/destination register addresses
//   immediate, category        immediate value and instruction category
//   flush                      squash held and incoming instruction
//   out_valid / out_ready      handshake with the execute stage
//   out_op1, out_op2           registered operands
//   out_src_addr, out_dst_addr registered addresses (used for stalled refresh)
//   out_category               registered category
module operand_fetch_stage #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned CAT_W   = 2,
  parameter int unsigned IMM_CAT = 1,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [WIDTH-1:0]  immediate,
  input  logic [CAT_W-1:0]  category,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_op1,
  output logic [WIDTH-1:0]  out_op2,
  output logic [ADDR_W-1:0] out_src_addr,
  output logic [ADDR_W-1:0] out_dst_addr,
  output logic [CAT_W-1:0]  out_category
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam logic [CAT_W-1:0] ImmCat = CAT_W'(IMM_CAT);
  localparam bit ZeroR0 = (ZERO_R0 != 0);

  logic [WIDTH-1:0]  regs_q [NREGS];
  logic              valid_q;
  logic [WIDTH-1:0]  op1_q, op2_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CAT_W-1:0]  cat_q;

  logic              wb_writable;
  logic [WIDTH-1:0]  rd_src, rd_dst, op2_sel;
  logic              accept, stall;

  // A write to the hardwired zero register is dropped everywhere: no store,
  // no bypass, no refresh.
  assign wb_writable = wb_en && !(ZeroR0 && (wb_addr == '0));

  always_comb begin
    rd_src = regs_q[src_addr];
    if (ZeroR0 && (src_addr == '0)) begin
      rd_src = '0;
    end else if (wb_writable && (wb_addr == src_addr)) begin
      rd_src = wb_data;
    end

    rd_dst = regs_q[dst_addr];
    if (ZeroR0 && (dst_addr == '0)) begin
      rd_dst = '0;
    end else if (wb_writable && (wb_addr == dst_addr)) begin
      rd_dst = wb_data;
    end

    op2_sel = (category == ImmCat) ? immediate : rd_dst;
  end

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign stall    = valid_q && !out_ready;

  // Register file; write-back ignores flush and the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_writable) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      cat_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      op1_q   <= rd_src;
      op2_q   <= op2_sel;
      src_q   <= src_addr;
      dst_q   <= dst_addr;
      cat_q   <= category;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end else if (stall) begin
      // Keep the held operands coherent with write-backs that land while the
      // instruction waits; an immediate operand 2 is never a register value.
      if (wb_writable && (wb_addr == src_q)) begin
        op1_q <= wb_data;
      end
      if (wb_writable && (cat_q != ImmCat) && (wb_addr == dst_q)) begin
        op2_q <= wb_data;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_src_addr = src_q;
  assign out_dst_addr = dst_q;
  assign out_category = cat_q;

endmodule
